// File: rtl/regfile_write_arbiter.sv
// Register-file writeback arbiter: ALU (A) and load (B) requests are buffered
// in per-source FIFOs and drained one per cycle, round-robin, into rf_* regs.

module regfile_write_arbiter_fifo #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic [2:0]  inReg,
   input  logic [15:0] inData,
   output logic        ready,
   output logic        notEmpty,
   output logic [2:0]  headReg,
   output logic [15:0] headData,
   output logic [7:0]  mask
);
   localparam int PW = (DEPTH > 2) ? 2 : 1;
   localparam int CW = PW + 1;

   logic [2:0]    regMem  [DEPTH];
   logic [15:0]   dataMem [DEPTH];
   logic [PW-1:0] wrPtr;
   logic [PW-1:0] rdPtr;
   logic [CW-1:0] count;

   assign ready    = (count < CW'(DEPTH));
   assign notEmpty = (count != '0);
   assign headReg  = regMem[rdPtr];
   assign headData = dataMem[rdPtr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + PW'(1);
         if (pop)  rdPtr <= rdPtr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         regMem[wrPtr]  <= inReg;
         dataMem[wrPtr] <= inData;
      end
   end

   // Only the count entries starting at the read pointer are live.
   always_comb begin
      mask = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (CW'(k) < count) mask[regMem[rdPtr + PW'(k)]] = 1'b1;
      end
   end
endmodule

module regfile_write_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [2:0]  a_reg,
   input  logic [15:0] a_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [2:0]  b_reg,
   input  logic [15:0] b_data,
   output logic        rf_we,
   output logic [2:0]  rf_waddr,
   output logic [15:0] rf_wdata,
   output logic [7:0]  pend_mask
);
   typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_t;

   src_t        rrPtr;
   logic        aPush, bPush;
   logic        aNotEmpty, bNotEmpty;
   logic        grantA, grantB;
   logic [2:0]  aHeadReg, bHeadReg;
   logic [15:0] aHeadData, bHeadData;
   logic [7:0]  aMask, bMask;

   assign aPush = a_valid & a_ready;
   assign bPush = b_valid & b_ready;

   regfile_write_arbiter_fifo #(.DEPTH(DEPTH)) fifoA (
      .clk(clk), .rst(rst), .push(aPush), .pop(grantA),
      .inReg(a_reg), .inData(a_data), .ready(a_ready), .notEmpty(aNotEmpty),
      .headReg(aHeadReg), .headData(aHeadData), .mask(aMask)
   );

   regfile_write_arbiter_fifo #(.DEPTH(DEPTH)) fifoB (
      .clk(clk), .rst(rst), .push(bPush), .pop(grantB),
      .inReg(b_reg), .inData(b_data), .ready(b_ready), .notEmpty(bNotEmpty),
      .headReg(bHeadReg), .headData(bHeadData), .mask(bMask)
   );

   always_comb begin
      grantA = aNotEmpty & (~bNotEmpty | (rrPtr == SRC_A));
      grantB = bNotEmpty & ~grantA;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rrPtr    <= SRC_A;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= grantA | grantB;
         if (grantA) begin
            rf_waddr <= aHeadReg;
            rf_wdata <= aHeadData;
            rrPtr    <= SRC_B;
         end else if (grantB) begin
            rf_waddr <= bHeadReg;
            rf_wdata <= bHeadData;
            rrPtr    <= SRC_A;
         end
      end
   end

   assign pend_mask = aMask | bMask | (rf_we ? (8'b1 << rf_waddr) : 8'b0);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (DEPTH = 2).

module tb_regfile_write_arbiter;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_valid = 1'b0, b_valid = 1'b0;
   logic        a_ready, b_ready;
   logic [2:0]  a_reg = '0, b_reg = '0;
   logic [15:0] a_data = '0, b_data = '0;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic [7:0]  pend_mask;

   int checks = 0;
   int errors = 0;

   regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pend_mask(pend_mask)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      a_valid = 1'b0;
      b_valid = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", rf_we); end
      checks++; if (rf_waddr !== 3'd0) begin errors++; $display("FAIL reset_waddr got %0d exp 0", rf_waddr); end
      checks++; if (rf_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0000", rf_wdata); end
      checks++; if (pend_mask !== 8'h00) begin errors++; $display("FAIL reset_pend got %h exp 00", pend_mask); end
      checks++; if ({a_ready, b_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready got %b exp 11", {a_ready, b_ready}); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      doReset();
      a_valid = 1'b1; a_reg = 3'd3; a_data = 16'h1234;
      tick();
      a_valid = 1'b0;
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_lat_we got %0b exp 0", rf_we); end
      checks++; if (pend_mask !== 8'h08) begin errors++; $display("FAIL single_buf_pend got %h exp 08", pend_mask); end
      tick();
      checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd3, 16'h1234}) begin
         errors++; $display("FAIL single_write got we=%0b a=%0d d=%h exp we=1 a=3 d=1234", rf_we, rf_waddr, rf_wdata); end
      checks++; if (pend_mask !== 8'h08) begin errors++; $display("FAIL single_stage_pend got %h exp 08", pend_mask); end
      tick();
      checks++; if ({rf_we, rf_wdata} !== {1'b0, 16'h1234}) begin
         errors++; $display("FAIL single_idle got we=%0b d=%h exp we=0 d=1234", rf_we, rf_wdata); end
      checks++; if (pend_mask !== 8'h00) begin errors++; $display("FAIL single_clear_pend got %h exp 00", pend_mask); end
   endtask

   task automatic test_contention();
      int expAddr[4];
      expAddr = '{1, 5, 2, 6};
      doReset();
      a_valid = 1'b1; a_reg = 3'd1; a_data = 16'h0111;
      b_valid = 1'b1; b_reg = 3'd5; b_data = 16'h0555;
      tick();
      a_reg = 3'd2; a_data = 16'h0222;
      b_reg = 3'd6; b_data = 16'h0666;
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'(expAddr[i]), 16'(expAddr[i] * 16'h0111)}) begin
            errors++; $display("FAIL contention_%0d got we=%0b a=%0d d=%h exp we=1 a=%0d", i, rf_we, rf_waddr, rf_wdata, expAddr[i]); end
         tick();
      end
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL contention_end_we got %0b exp 0", rf_we); end
   endtask

   task automatic test_backpressure();
      doReset();
      a_valid = 1'b1; a_reg = 3'd1; a_data = 16'hA000;
      b_valid = 1'b1; b_reg = 3'd2; b_data = 16'hB000;
      tick();
      tick();
      checks++; if ({a_ready, b_ready, rf_waddr} !== {1'b1, 1'b0, 3'd1}) begin
         errors++; $display("FAIL bp_edge2 got ar=%0b br=%0b a=%0d exp ar=1 br=0 a=1", a_ready, b_ready, rf_waddr); end
      tick();
      checks++; if ({a_ready, b_ready, rf_waddr} !== {1'b0, 1'b1, 3'd2}) begin
         errors++; $display("FAIL bp_full got ar=%0b br=%0b a=%0d exp ar=0 br=1 a=2", a_ready, b_ready, rf_waddr); end
      tick();
      checks++; if ({a_ready, b_ready, rf_waddr} !== {1'b1, 1'b0, 3'd1}) begin
         errors++; $display("FAIL bp_release got ar=%0b br=%0b a=%0d exp ar=1 br=0 a=1", a_ready, b_ready, rf_waddr); end
      checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL bp_we got %0b exp 1", rf_we); end
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic test_same_reg();
      doReset();
      a_valid = 1'b1; a_reg = 3'd4; a_data = 16'hAAAA;
      b_valid = 1'b1; b_reg = 3'd4; b_data = 16'hBBBB;
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      checks++; if ({rf_we, pend_mask} !== {1'b0, 8'h10}) begin
         errors++; $display("FAIL same_buf got we=%0b pend=%h exp we=0 pend=10", rf_we, pend_mask); end
      tick();
      checks++; if ({rf_we, rf_waddr, rf_wdata, pend_mask} !== {1'b1, 3'd4, 16'hAAAA, 8'h10}) begin
         errors++; $display("FAIL same_first got we=%0b a=%0d d=%h pend=%h exp 1 4 AAAA 10", rf_we, rf_waddr, rf_wdata, pend_mask); end
      tick();
      checks++; if ({rf_we, rf_waddr, rf_wdata, pend_mask} !== {1'b1, 3'd4, 16'hBBBB, 8'h10}) begin
         errors++; $display("FAIL same_second got we=%0b a=%0d d=%h pend=%h exp 1 4 BBBB 10", rf_we, rf_waddr, rf_wdata, pend_mask); end
      tick();
      checks++; if ({rf_we, pend_mask} !== {1'b0, 8'h00}) begin
         errors++; $display("FAIL same_done got we=%0b pend=%h exp we=0 pend=00", rf_we, pend_mask); end
   endtask

   task automatic test_mid_reset();
      doReset();
      a_valid = 1'b1; a_reg = 3'd1; a_data = 16'h1111;
      b_valid = 1'b1; b_reg = 3'd2; b_data = 16'h2222;
      tick();
      a_reg = 3'd3; a_data = 16'h3333;
      b_reg = 3'd5; b_data = 16'h5555;
      tick();
      checks++; if (pend_mask !== 8'h2E) begin errors++; $display("FAIL midrst_pre_pend got %h exp 2e", pend_mask); end
      a_reg = 3'd7;
      b_reg = 3'd7;
      rst = 1'b1;
      #1;
      checks++; if ({rf_we, pend_mask, a_ready, b_ready} !== {1'b0, 8'h00, 2'b11}) begin
         errors++; $display("FAIL midrst_async got we=%0b pend=%h rdy=%b%b exp 0 00 11", rf_we, pend_mask, a_ready, b_ready); end
      tick();
      checks++; if ({rf_we, pend_mask} !== {1'b0, 8'h00}) begin
         errors++; $display("FAIL midrst_hold got we=%0b pend=%h exp 0 00", rf_we, pend_mask); end
      a_valid = 1'b0; b_valid = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if ({rf_we, pend_mask} !== {1'b0, 8'h00}) begin
            errors++; $display("FAIL midrst_stale_%0d got we=%0b pend=%h exp 0 00", i, rf_we, pend_mask); end
      end
   endtask

   task automatic test_wrap();
      int n;
      n = 3 * DEPTH;
      doReset();
      b_valid = 1'b1;
      for (int i = 0; i <= n; i++) begin
         if (i == n) b_valid = 1'b0;
         b_reg = 3'(i);
         b_data = 16'(i);
         tick();
         if (i >= 1) begin
            checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'(i - 1), 16'(i - 1)}) begin
               errors++; $display("FAIL wrap_%0d got we=%0b a=%0d d=%h exp we=1 a=%0d d=%0d", i - 1, rf_we, rf_waddr, rf_wdata, i - 1, i - 1); end
         end
      end
      tick();
      checks++; if ({rf_we, b_ready} !== {1'b0, 1'b1}) begin
         errors++; $display("FAIL wrap_end got we=%0b br=%0b exp we=0 br=1", rf_we, b_ready); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_same_reg();
      test_mid_reset();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
